// File: rtl/axi_wr_stream.sv
// AXI-3 stream-to-memory writer: splits a beat stream into INCR bursts (<= MAX_BURST_LEN, never crossing 4 KB).
// AW rises two cycles after start is taken; W is a combinational pass-through of the stream, stalls hold in place.
module axi_wr_stream #(
  parameter int AXI_WR_ID_WIDTH      = 8,
  parameter int AXI_WR_ADDR_WIDTH    = 32,
  parameter int AXI_WR_BUS_WIDTH     = 64,
  parameter int AXI_WR_MAX_BURST_LEN = 16,
  parameter int AXI_WR_COUNT_WIDTH   = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [AXI_WR_ID_WIDTH-1:0]     id,
  input  logic [AXI_WR_ADDR_WIDTH-1:0]   addr,
  input  logic [AXI_WR_COUNT_WIDTH-1:0]  beats,
  input  logic [AXI_WR_BUS_WIDTH-1:0]    s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [1:0]                     status,
  output logic [AXI_WR_ID_WIDTH-1:0]     aw_id,
  output logic [AXI_WR_ADDR_WIDTH-1:0]   aw_addr,
  output logic [3:0]                     aw_len,
  output logic [2:0]                     aw_size,
  output logic [1:0]                     aw_burst,
  output logic [2:0]                     aw_prot,
  output logic                           aw_valid,
  input  logic                           aw_ready,
  output logic [AXI_WR_ID_WIDTH-1:0]     w_id,
  output logic [AXI_WR_BUS_WIDTH-1:0]    w_data,
  output logic [AXI_WR_BUS_WIDTH/8-1:0]  w_strb,
  output logic                           w_last,
  output logic                           w_valid,
  input  logic                           w_ready,
  input  logic [AXI_WR_ID_WIDTH-1:0]     b_id,
  input  logic [1:0]                     b_resp,
  input  logic                           b_valid,
  output logic                           b_ready
);

  localparam int BYTES  = AXI_WR_BUS_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int AW     = AXI_WR_ADDR_WIDTH;
  localparam int CW     = AXI_WR_COUNT_WIDTH;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP, DONE} state_t;

  state_t                     state;
  logic [AXI_WR_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]              cur_addr;
  logic [CW-1:0]              remaining;
  logic [CW-1:0]              remaining_next;
  logic [3:0]                 beat_cnt;
  logic [31:0]                page_room;
  logic [31:0]                burst_len;
  logic                       unused_b_id;

  assign unused_b_id = ^b_id;

  // Beats left before the next 4 KB page; cur_addr is always bus aligned so this divides exactly.
  always_comb begin
    page_room = 32'((13'd4096 - {1'b0, cur_addr[11:0]}) >> BSHIFT);
    burst_len = 32'(AXI_WR_MAX_BURST_LEN);
    if (page_room < burst_len) burst_len = page_room;
    if (32'(remaining) < burst_len) burst_len = 32'(remaining);
  end

  assign remaining_next = remaining - (CW'(aw_len) + CW'(1));

  assign aw_id    = id_q;
  assign w_id     = id_q;
  assign aw_size  = 3'(BSHIFT);
  assign aw_burst = 2'b01;
  assign aw_prot  = 3'b000;
  assign w_strb   = '1;
  assign w_valid  = (state == DATA) && s_valid;
  assign s_ready  = (state == DATA) && w_ready;
  assign w_last   = (state == DATA) && (beat_cnt == aw_len);
  assign w_data   = (state == DATA) ? s_data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      status    <= 2'd0;
      aw_valid  <= 1'b0;
      b_ready   <= 1'b0;
      aw_addr   <= '0;
      aw_len    <= '0;
      id_q      <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && status == 2'd0) begin
            id_q      <= id;
            cur_addr  <= addr & ALIGN_MASK;
            remaining <= beats;
            status    <= 2'd1;
            state     <= (beats == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          aw_addr  <= cur_addr;
          aw_len   <= 4'(burst_len - 32'd1);
          aw_valid <= 1'b1;
          state    <= ADDR;
        end
        ADDR: begin
          if (aw_valid && aw_ready) begin
            aw_valid <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_valid && w_ready) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (w_last) begin
              b_ready <= 1'b1;
              state   <= RESP;
            end
          end
        end
        RESP: begin
          if (b_valid && b_ready) begin
            b_ready <= 1'b0;
            if (b_resp[1]) begin
              status <= 2'd3;
              state  <= DONE;
            end else begin
              cur_addr  <= cur_addr + ((AW'(aw_len) + AW'(1)) << BSHIFT);
              remaining <= remaining_next;
              if (remaining_next == '0) begin
                status <= 2'd2;
                state  <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
        end
        DONE: begin
          // A zero-beat transfer shows busy for one cycle before reporting completion.
          if (status == 2'd1) begin
            status <= 2'd2;
          end else if (!start) begin
            status <= 2'd0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_stream.sv
// Randomized bench for axi_wr_stream: a slave/stream driver records every handshake and tasks
// compare the record against burst lists computed from the address/length rules.
module tb_axi_wr_stream;
  localparam int IDW = 8, AW = 32, BW = 64, MAXB = 16, CW = 16, BYTES = BW / 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [IDW-1:0] id = '0;
  logic [AW-1:0] addr = '0;
  logic [CW-1:0] beats = '0;
  logic [BW-1:0] s_data = '0;
  logic s_valid = 1'b0, s_ready;
  logic [1:0] status;
  logic [IDW-1:0] aw_id, w_id;
  logic [AW-1:0] aw_addr;
  logic [3:0] aw_len;
  logic [2:0] aw_size, aw_prot;
  logic [1:0] aw_burst;
  logic aw_valid, aw_ready = 1'b0;
  logic [BW-1:0] w_data;
  logic [BYTES-1:0] w_strb;
  logic w_last, w_valid, w_ready = 1'b0;
  logic [IDW-1:0] b_id = '0;
  logic [1:0] b_resp = 2'd0;
  logic b_valid = 1'b0, b_ready;

  axi_wr_stream dut (
    .clock(clock), .reset_n(reset_n), .start(start), .id(id), .addr(addr), .beats(beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .status(status),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clock = ~clock;

  int passed = 0, total = 0;
  logic bp = 1'b0;
  int err_burst = -1, bcount = 0, sidx = 0;
  logic b_pending = 1'b0;
  int aw_valid_cycles = 0, w_valid_cycles = 0;
  logic [BW-1:0]  stream[$];
  logic [AW-1:0]  cap_aw_addr[$];
  logic [3:0]     cap_aw_len[$];
  logic [BW-1:0]  cap_w_data[$];
  logic [IDW-1:0] cap_w_id[$];
  logic           cap_w_last[$];
  logic [AW-1:0]  exp_addr[$];
  int             exp_len[$];

  // Slave + stream source: inputs change on the falling edge, handshakes are recorded 1ns later,
  // which is exactly what the following rising edge will see.
  initial forever begin
    @(negedge clock);
    s_valid  = (sidx < stream.size()) && (!bp || $urandom_range(0, 1) == 1);
    s_data   = (sidx < stream.size()) ? stream[sidx] : '0;
    w_ready  = !bp || $urandom_range(0, 2) != 0;
    aw_ready = !bp || $urandom_range(0, 1) == 1;
    b_valid  = b_pending && (!bp || $urandom_range(0, 1) == 1);
    b_resp   = (bcount == err_burst) ? 2'd2 : 2'd0;
    b_id     = id;
    #1;
    if (aw_valid) aw_valid_cycles++;
    if (w_valid) w_valid_cycles++;
    if (aw_valid && aw_ready) begin
      cap_aw_addr.push_back(aw_addr);
      cap_aw_len.push_back(aw_len);
    end
    if (w_valid && w_ready) begin
      cap_w_data.push_back(w_data);
      cap_w_id.push_back(w_id);
      cap_w_last.push_back(w_last);
      sidx++;
      if (w_last) b_pending = 1'b1;
    end
    if (b_valid && b_ready) begin
      b_pending = 1'b0;
      bcount++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_caps();
    stream.delete(); cap_aw_addr.delete(); cap_aw_len.delete();
    cap_w_data.delete(); cap_w_id.delete(); cap_w_last.delete();
    sidx = 0; bcount = 0; b_pending = 1'b0; aw_valid_cycles = 0; w_valid_cycles = 0;
  endtask

  task automatic build_model(input logic [AW-1:0] a0, input int n, input int max_bursts);
    logic [AW-1:0] a;
    int rem, room, len;
    exp_addr.delete(); exp_len.delete();
    a = a0 & ~32'(BYTES - 1);
    rem = n;
    while (rem > 0 && exp_addr.size() < max_bursts) begin
      room = (4096 - int'(a[11:0])) / BYTES;
      len = rem;
      if (len > MAXB) len = MAXB;
      if (len > room) len = room;
      exp_addr.push_back(a);
      exp_len.push_back(len);
      a = a + AW'(len * BYTES);
      rem -= len;
    end
  endtask

  function automatic int aw_diff();
    int d = 0;
    if (cap_aw_addr.size() != exp_addr.size()) return 1000 + cap_aw_addr.size();
    foreach (exp_addr[i])
      if (cap_aw_addr[i] !== exp_addr[i] || cap_aw_len[i] !== 4'(exp_len[i] - 1)) d++;
    return d;
  endfunction

  function automatic int data_diff();
    int n = 0;
    int d = 0;
    foreach (exp_len[i]) n += exp_len[i];
    if (cap_w_data.size() != n) return 1000 + cap_w_data.size();
    for (int k = 0; k < n; k++)
      if (cap_w_data[k] !== stream[k] || cap_w_id[k] !== id) d++;
    return d;
  endfunction

  function automatic int last_diff();
    int k = 0;
    int d = 0;
    foreach (exp_len[i])
      for (int j = 0; j < exp_len[i]; j++) begin
        if (k >= cap_w_last.size()) d++;
        else if (cap_w_last[k] !== (j == exp_len[i] - 1)) d++;
        k++;
      end
    if (cap_w_last.size() != k) d++;
    return d;
  endfunction

  task automatic do_xfer(input logic [AW-1:0] a, input int n, input logic [IDW-1:0] idv,
                         input int ebur, output logic ok, output logic [1:0] st1);
    clear_caps();
    err_burst = ebur;
    for (int i = 0; i < n + 16; i++) stream.push_back({$urandom, $urandom});
    id = idv; addr = a; beats = CW'(n);
    @(negedge clock); start = 1'b1;
    @(negedge clock); #2; st1 = status;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (status == 2'd2 || status == 2'd3) begin ok = 1'b1; break; end
      @(negedge clock); #2;
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({status, aw_valid, w_valid, w_last, b_ready, s_ready} !== 7'b0) begin
      $display("FAIL reset_ctrl: got %b want 0", {status, aw_valid, w_valid, w_last, b_ready, s_ready});
    end else passed++;
    total++;
    if ({aw_addr, aw_len} !== 36'h0) $display("FAIL reset_aw: got %h/%h want 0/0", aw_addr, aw_len);
    else passed++;
    total++;
    if ({aw_size, aw_burst, aw_prot, w_strb} !== {3'd3, 2'b01, 3'd0, 8'hff})
      $display("FAIL constants: got %h want %h", {aw_size, aw_burst, aw_prot, w_strb}, {3'd3, 2'b01, 3'd0, 8'hff});
    else passed++;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic ok; logic [1:0] st1;
    bp = 1'b0;
    build_model(32'h1000, 40, 99);
    do_xfer(32'h1000, 40, 8'h5a, -1, ok, st1);
    total++; if (!ok) $display("FAIL basic_timeout: no completion"); else passed++;
    total++; if (st1 !== 2'd1) $display("FAIL basic_busy: got %0d want 1", st1); else passed++;
    total++; if (status !== 2'd2) $display("FAIL basic_status: got %0d want 2", status); else passed++;
    total++; if (aw_diff() != 0) $display("FAIL basic_bursts: %0d diffs want 0", aw_diff()); else passed++;
    total++; if (data_diff() != 0) $display("FAIL basic_data: %0d diffs want 0", data_diff()); else passed++;
    total++; if (last_diff() != 0) $display("FAIL basic_last: %0d diffs want 0", last_diff()); else passed++;
    total++; if (aw_id !== 8'h5a) $display("FAIL basic_awid: got %h want 5a", aw_id); else passed++;
    start = 1'b0;
    @(negedge clock); #2;
    total++; if (status !== 2'd0) $display("FAIL basic_release: got %0d want 0", status); else passed++;
  endtask

  task automatic test_4k_split();
    logic ok; logic [1:0] st1;
    bp = 1'b0;
    build_model(32'h1FC0, 20, 99);
    do_xfer(32'h1FC0, 20, 8'h11, -1, ok, st1);
    total++; if (!ok || status !== 2'd2) $display("FAIL split_status: got %0d want 2", status); else passed++;
    total++; if (aw_diff() != 0) $display("FAIL split_bursts: %0d diffs want 0", aw_diff()); else passed++;
    total++;
    if (cap_aw_addr.size() != 2 || cap_aw_addr[1] !== 32'h2000 || cap_aw_len[1] !== 4'd11)
      $display("FAIL split_second: got %0d bursts want 2 at 2000 len 11", cap_aw_addr.size());
    else passed++;
    start = 1'b0; repeat (2) @(negedge clock);
  endtask

  task automatic test_error();
    logic ok; logic [1:0] st1;
    bp = 1'b0;
    build_model(32'h4000, 40, 1);
    do_xfer(32'h4000, 40, 8'h22, 0, ok, st1);
    total++; if (!ok || status !== 2'd3) $display("FAIL err_status: got %0d want 3", status); else passed++;
    total++; if (cap_w_data.size() != 16) $display("FAIL err_beats: got %0d want 16", cap_w_data.size()); else passed++;
    total++; if (aw_diff() != 0) $display("FAIL err_bursts: %0d diffs want 0", aw_diff()); else passed++;
    repeat (10) @(negedge clock);
    #2;
    total++;
    if (aw_valid_cycles != 1 || cap_aw_addr.size() != 1 || status !== 2'd3)
      $display("FAIL err_quiet: got aw cycles %0d status %0d want 1 and 3", aw_valid_cycles, status);
    else passed++;
    start = 1'b0; repeat (2) @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic ok; logic [1:0] st1;
    logic [AW-1:0] a;
    int n;
    bp = 1'b1;
    for (int it = 0; it < 5; it++) begin
      a = $urandom;
      n = $urandom_range(1, 60);
      if (it == 0) n = 33;
      if (it == 1) begin a = 32'hFFFF_FFC8; n = 30; end
      build_model(a, n, 99);
      do_xfer(a, n, 8'(it + 1), -1, ok, st1);
      total++; if (!ok || status !== 2'd2) $display("FAIL bp_status[%0d]: got %0d want 2", it, status); else passed++;
      total++; if (aw_diff() != 0) $display("FAIL bp_bursts[%0d]: %0d diffs want 0", it, aw_diff()); else passed++;
      total++; if (data_diff() != 0) $display("FAIL bp_data[%0d]: %0d diffs want 0", it, data_diff()); else passed++;
      total++; if (last_diff() != 0) $display("FAIL bp_last[%0d]: %0d diffs want 0", it, last_diff()); else passed++;
      start = 1'b0; repeat (2) @(negedge clock);
    end
    bp = 1'b0;
  endtask

  task automatic test_zero_and_unaligned();
    logic ok; logic [1:0] st1;
    bp = 1'b0;
    do_xfer(32'h2000, 0, 8'h33, -1, ok, st1);
    total++; if (st1 !== 2'd1) $display("FAIL zero_busy: got %0d want 1", st1); else passed++;
    total++; if (!ok || status !== 2'd2) $display("FAIL zero_status: got %0d want 2", status); else passed++;
    total++;
    if (aw_valid_cycles != 0 || w_valid_cycles != 0)
      $display("FAIL zero_quiet: got aw %0d w %0d want 0 0", aw_valid_cycles, w_valid_cycles);
    else passed++;
    start = 1'b0; repeat (2) @(negedge clock);
    build_model(32'h1004, 3, 99);
    do_xfer(32'h1004, 3, 8'h44, -1, ok, st1);
    total++;
    if (cap_aw_addr.size() != 1 || cap_aw_addr[0] !== 32'h1000 || cap_aw_len[0] !== 4'd2)
      $display("FAIL unaligned_addr: got %0d bursts want 1 at 1000 len 2", cap_aw_addr.size());
    else passed++;
    total++; if (data_diff() != 0) $display("FAIL unaligned_data: %0d diffs want 0", data_diff()); else passed++;
    start = 1'b0; repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic ok; logic [1:0] st1;
    bp = 1'b0;
    clear_caps();
    err_burst = -1;
    for (int i = 0; i < 56; i++) stream.push_back({$urandom, $urandom});
    id = 8'h66; addr = 32'h3000; beats = 16'd40;
    @(negedge clock); start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock); #2;
      if (cap_w_data.size() >= 5) break;
    end
    @(posedge clock); #1;
    total++; if (w_valid !== 1'b1) $display("FAIL mid_active: got w_valid %b want 1", w_valid); else passed++;
    reset_n = 1'b0; start = 1'b0;
    #1;
    total++;
    if ({status, aw_valid, w_valid, w_last, b_ready, s_ready, aw_addr, aw_len} !== 43'h0)
      $display("FAIL mid_reset: got %h want 0", {status, aw_valid, w_valid, w_last, b_ready, s_ready, aw_addr, aw_len});
    else passed++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    build_model(32'h5000, 10, 99);
    do_xfer(32'h5000, 10, 8'h77, -1, ok, st1);
    total++; if (!ok || status !== 2'd2) $display("FAIL post_status: got %0d want 2", status); else passed++;
    total++; if (aw_diff() != 0) $display("FAIL post_bursts: %0d diffs want 0", aw_diff()); else passed++;
    total++; if (data_diff() != 0) $display("FAIL post_data: %0d diffs want 0", data_diff()); else passed++;
    start = 1'b0; repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4k_split();
    test_error();
    test_backpressure();
    test_zero_and_unaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_wr_stream.md
Name: axi_wr_stream

Overview:
AXI-3 write master that moves an arbitrary-length stream of bus-width beats to memory. It splits the transfer into INCR bursts of up to MAX_BURST_LEN beats, and no burst crosses a 4 KB boundary. Data enters through a valid/ready stream port and is passed straight onto the W channel. It keeps the start/status handshake of the single-burst writer, so it drops into the same F2H bridge path as that writer's successor.

Parameters:
AXI_WR_ID_WIDTH, 8, width of id / aw_id / w_id / b_id
AXI_WR_ADDR_WIDTH, 32, address width
AXI_WR_BUS_WIDTH, 64, data bus width in bits (power of 2, 8..1024); BYTES = AXI_WR_BUS_WIDTH/8
AXI_WR_MAX_BURST_LEN, 16, maximum beats per burst (1..16)
AXI_WR_COUNT_WIDTH, 16, width of beats counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request a transfer (level); sampled when status==0
id  in  AXI_WR_ID_WIDTH  transaction ID, latched at start
addr  in  AXI_WR_ADDR_WIDTH  start byte address, latched at start; low log2(BYTES) bits treated as 0
beats  in  AXI_WR_COUNT_WIDTH  total beats to write, latched at start
s_data  in  AXI_WR_BUS_WIDTH  stream data
s_valid  in  1  stream data valid
s_ready  out  1  stream data accepted (= w_ready in DATA state)
status  out  2  0 ready, 1 busy, 2 completed ok, 3 error
aw_id/aw_addr/aw_len[3:0]/aw_size[2:0]/aw_burst[1:0]/aw_prot[2:0]  out  -  AW channel, registered
aw_valid  out 1; aw_ready  in 1
w_id/w_data/w_strb(BYTES)/w_last  out  -  W channel
w_valid  out 1; w_ready  in 1
b_id  in  AXI_WR_ID_WIDTH; b_resp  in  2; b_valid  in 1; b_ready  out 1

Behaviour:
- Reset: status=0, aw_valid=0, w_valid=0, w_last=0, b_ready=0, s_ready=0, aw_addr=0, aw_len=0, state=IDLE. Reset mid-operation abandons the transfer immediately and the bus goes quiet; no completion of an outstanding burst.
- Constants: aw_size=log2(BYTES), aw_burst=INCR (01), aw_prot=0, w_strb=all ones, aw_id=w_id=latched id.
- States: IDLE, CALC, ADDR, DATA, RESP, DONE. One burst is outstanding at a time.
- IDLE: if start && status==0, do the following:
  - Latch id, aligned addr and remaining=beats; set status=1.
  - If beats==0, go to DONE with status=2 on the next cycle; no AXI traffic.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - len = min(remaining, AXI_WR_MAX_BURST_LEN, (4096 - cur_addr[11:0])/BYTES).
  - Register aw_addr=cur_addr and aw_len=len-1, and set aw_valid=1. Go to ADDR.
  - aw_valid therefore rises 2 cycles after start is sampled.
- ADDR: on aw_valid&&aw_ready, drop aw_valid, clear beat_cnt=0, go to DATA. Data is never presented before the AW handshake.
- DATA:
  - w_valid=s_valid; s_ready=w_ready; w_data=s_data (combinational pass-through).
  - w_last = (beat_cnt==aw_len).
  - On each w_valid&&w_ready, beat_cnt++.
  - On the beat with w_last, go to RESP with b_ready=1. w_valid, s_ready and w_last are 0 outside DATA.
- RESP: on b_valid&&b_ready, b_ready drops. b_id is not checked.
  - If b_resp>=2 (SLVERR/DECERR), set status=3 and go to DONE; the remaining bursts are aborted.
  - Otherwise cur_addr += (aw_len+1)*BYTES and remaining -= aw_len+1. If remaining==0, set status=2 and go to DONE; else go to CALC.
- DONE: status holds 2 or 3 until start is low, then status=0 and state=IDLE. If start is still high, no new transfer begins.
- Address arithmetic wraps modulo 2^AXI_WR_ADDR_WIDTH; no burst ever crosses a 4 KB page.
- Simultaneous events: a stream stall (s_valid=0) or slave stall (w_ready=0) in DATA simply holds; no beat is lost or duplicated.

Test Plan:
- BUS 64, MAX 16, addr=0x1000, beats=40, all ready high -> 3 bursts: aw_addr 0x1000/0x1080/0x1100, aw_len 15/15/7, 40 W beats with w_last on beats 16, 32 and 40, status 1 then 2; status returns to 0 one cycle after start falls.
- 4 KB split: addr=0x1FC0, beats=20 -> bursts at 0x1FC0 (aw_len 7) and 0x2000 (aw_len 11); status 2.
- Error: beats=40, slave returns b_resp=2 on the first burst -> exactly 16 beats and one AW handshake occur, then status=3; no further aw_valid.
- Backpressure: random s_valid and w_ready toggling over beats=33 -> the W data sequence equals the input stream in order, 33 handshakes, w_last on beats 16, 32 and 33.
- beats=0 -> status 1 then 2, aw_valid and w_valid never asserted; unaligned addr=0x1004 (BYTES=8) -> aw_addr=0x1000.
- reset_n low in DATA after 5 beats -> all outputs 0 asynchronously; a new start after reset gives a clean transfer from the new addr.
